// File: rtl/grid_render.sv
// grid_render: three-stage pixel pipeline that turns VGA raster coordinates
// into a colour for a cell-based playfield (empty / body / food / head).
//
// Ports
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_x, i_y              current pixel coordinates from the timing generator
//   i_active/i_hsync/
//   i_vsync               display enable and syncs aligned with i_x/i_y
//                         (i_vsync is active-low)
//   o_addr                cell address to the grid memory read port
//   i_cell                cell code returned by the memory one cycle after
//                         it registers o_addr
//   o_rgb                 {R[3:0],G[3:0],B[3:0]}, 3 cycles after i_x/i_y
//   o_active/o_hsync/
//   o_vsync               sideband inputs delayed 3 cycles to match o_rgb
//   o_frame_tick          one-cycle pulse per falling edge of i_vsync
//
// Pipeline
//   stage 1: grid hit test, cell address and edge flag are registered
//   stage 2: the memory registers o_addr; sideband travels alongside
//   stage 3: colour lookup from i_cell and the stage-2 sideband
module grid_render #(
   parameter int CELL_PX    = 32,
   parameter int GRID_W     = 14,
   parameter int GRID_H     = 14,
   parameter int X0         = 96,
   parameter int Y0         = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [9:0]            i_x,
   input  logic [9:0]            i_y,
   input  logic                  i_active,
   input  logic                  i_hsync,
   input  logic                  i_vsync,
   output logic [ADDR_WIDTH-1:0] o_addr,
   input  logic [DATA_WIDTH-1:0] i_cell,
   output logic [11:0]           o_rgb,
   output logic                  o_active,
   output logic                  o_hsync,
   output logic                  o_vsync,
   output logic                  o_frame_tick
);

   localparam int          SHIFT = $clog2(CELL_PX);
   localparam logic [9:0]  MASK  = 10'(CELL_PX - 1);
   localparam logic [10:0] X_LO  = 11'(X0);
   localparam logic [10:0] X_HI  = 11'(X0 + GRID_W * CELL_PX);
   localparam logic [10:0] Y_LO  = 11'(Y0);
   localparam logic [10:0] Y_HI  = 11'(Y0 + GRID_H * CELL_PX);

   // sideband bundles are {active, hsync, vsync}; idle value is 3'b011
   localparam logic [2:0]  SYNC_IDLE = 3'b011;

   // ---------------- stage 1 (combinational part) ----------------
   logic                  in_grid_next;
   logic                  is_edge_next;
   logic [9:0]            dx, dy, col, row;
   logic [ADDR_WIDTH-1:0] addr_next;

   always_comb begin
      // range is tested on the raw coordinates first so that pixels left of
      // or above the grid can never wrap around into it after subtraction
      in_grid_next = ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI) &&
                     ({1'b0, i_y} >= Y_LO) && ({1'b0, i_y} < Y_HI);
      dx  = i_x - 10'(X0);
      dy  = i_y - 10'(Y0);
      col = dx >> SHIFT;
      row = dy >> SHIFT;
      is_edge_next = in_grid_next && (((dx & MASK) == 10'd0) || ((dy & MASK) == 10'd0));
      addr_next = '0;
      if (in_grid_next) begin
         addr_next = ADDR_WIDTH'(20'(row) * 20'(GRID_W) + 20'(col));
      end
   end

   // ---------------- pipeline registers ----------------
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  in_grid_s1_reg, in_grid_s2_reg;
   logic                  is_edge_s1_reg, is_edge_s2_reg;
   logic [2:0]            sync_s1_reg, sync_s2_reg, sync_s3_reg;
   logic [11:0]           rgb_reg;
   logic [11:0]           rgb_next;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_reg       <= '0;
         in_grid_s1_reg <= 1'b0;
         is_edge_s1_reg <= 1'b0;
         sync_s1_reg    <= SYNC_IDLE;
         in_grid_s2_reg <= 1'b0;
         is_edge_s2_reg <= 1'b0;
         sync_s2_reg    <= SYNC_IDLE;
         sync_s3_reg    <= SYNC_IDLE;
         rgb_reg        <= 12'h000;
      end else begin
         addr_reg       <= addr_next;
         in_grid_s1_reg <= in_grid_next;
         is_edge_s1_reg <= is_edge_next;
         sync_s1_reg    <= {i_active, i_hsync, i_vsync};
         in_grid_s2_reg <= in_grid_s1_reg;
         is_edge_s2_reg <= is_edge_s1_reg;
         sync_s2_reg    <= sync_s1_reg;
         sync_s3_reg    <= sync_s2_reg;
         rgb_reg        <= rgb_next;
      end
   end

   // ---------------- frame tick and blink counter ----------------
   logic       vsync_reg;
   logic       frame_tick_reg;
   logic [4:0] frame_cnt_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vsync_reg      <= 1'b1;
         frame_tick_reg <= 1'b0;
         frame_cnt_reg  <= 5'd0;
      end else begin
         vsync_reg      <= i_vsync;
         // registered fall detect: never high in the cycle after reset
         frame_tick_reg <= vsync_reg & ~i_vsync;
         if (frame_tick_reg) begin
            frame_cnt_reg <= frame_cnt_reg + 5'd1;
         end
      end
   end

   // ---------------- stage 3 colour lookup ----------------
   always_comb begin
      rgb_next = 12'h000;
      if (sync_s2_reg[2] && in_grid_s2_reg) begin
         if (is_edge_s2_reg) begin
            rgb_next = 12'h444;
         end else begin
            case (i_cell)
               DATA_WIDTH'(0): rgb_next = 12'h222;
               DATA_WIDTH'(1): rgb_next = 12'h0F0;
               DATA_WIDTH'(2): rgb_next = frame_cnt_reg[4] ? 12'hF00 : 12'h222;
               DATA_WIDTH'(3): rgb_next = 12'hFF0;
               default:        rgb_next = 12'h222;
            endcase
         end
      end
   end

   assign o_addr       = addr_reg;
   assign o_rgb        = rgb_reg;
   assign o_active     = sync_s3_reg[2];
   assign o_hsync      = sync_s3_reg[1];
   assign o_vsync      = sync_s3_reg[0];
   assign o_frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_grid_render.sv
// tb_grid_render: randomized and directed stimulus for grid_render, checked
// against a coordinate-arithmetic reference model. The bench also plays the
// role of the grid memory (registered read).
module tb_grid_render;

   localparam int CELL_PX = 32;
   localparam int GRID_W  = 14;
   localparam int GRID_H  = 14;
   localparam int X0      = 96;
   localparam int Y0      = 16;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [9:0] i_x = '0, i_y = '0;
   logic       i_active = 1'b0, i_hsync = 1'b1, i_vsync = 1'b1;
   logic [7:0] o_addr;
   logic [1:0] i_cell;
   logic [11:0] o_rgb;
   logic       o_active, o_hsync, o_vsync, o_frame_tick;

   always #5 i_clk = ~i_clk;

   grid_render dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y),
      .i_active(i_active), .i_hsync(i_hsync), .i_vsync(i_vsync),
      .o_addr(o_addr), .i_cell(i_cell), .o_rgb(o_rgb),
      .o_active(o_active), .o_hsync(o_hsync), .o_vsync(o_vsync),
      .o_frame_tick(o_frame_tick)
   );

   // grid memory with a registered read port
   logic [1:0] mem [0:255];
   always @(posedge i_clk) i_cell <= mem[o_addr];

   typedef struct packed {
      logic [7:0]  addr;
      logic [11:0] rgb;
      logic        act, hs, vs, quiet;
   } ent_t;

   ent_t ring [4];
   int   tests = 0, fails = 0;
   int   n = 0, falls = 0, falls_total = 0, ticks = 0, last_fall = -100;
   bit   prev_vs = 1'b1, prev_rst = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, n);
      end
   endtask

   function automatic logic [11:0] model_rgb(int x, int y, bit act, int frames);
      int c, r;
      if (!act) return 12'h000;
      if (x < X0 || x >= X0 + GRID_W * CELL_PX || y < Y0 || y >= Y0 + GRID_H * CELL_PX)
         return 12'h000;
      if ((x - X0) % CELL_PX == 0 || (y - Y0) % CELL_PX == 0) return 12'h444;
      c = (x - X0) / CELL_PX;
      r = (y - Y0) / CELL_PX;
      case (mem[r * GRID_W + c])
         2'd0: return 12'h222;
         2'd1: return 12'h0F0;
         2'd2: return ((frames % 32) >= 16) ? 12'hF00 : 12'h222;
         default: return 12'hFF0;
      endcase
   endfunction

   function automatic logic [7:0] model_addr(int x, int y);
      if (x < X0 || x >= X0 + GRID_W * CELL_PX || y < Y0 || y >= Y0 + GRID_H * CELL_PX)
         return 8'd0;
      return 8'(((y - Y0) / CELL_PX) * GRID_W + (x - X0) / CELL_PX);
   endfunction

   // one transaction: check outputs owed by earlier transactions, then drive
   task automatic step(input bit rst, input int x, input int y,
                       input bit act, input bit hs, input bit vs);
      ent_t e;
      @(negedge i_clk);
      if (n >= 1) chk("addr", 32'(o_addr), 32'(ring[(n - 1) % 4].addr));
      if (n >= 3) begin
         chk("active", 32'(o_active), 32'(ring[(n - 3) % 4].act));
         chk("hsync",  32'(o_hsync),  32'(ring[(n - 3) % 4].hs));
         chk("vsync",  32'(o_vsync),  32'(ring[(n - 3) % 4].vs));
         if (ring[(n - 3) % 4].quiet) chk("rgb", 32'(o_rgb), 32'(ring[(n - 3) % 4].rgb));
      end
      if (prev_rst) chk("tick_rst", 32'(o_frame_tick), 32'd0);
      if (o_frame_tick) ticks++;
      $display("[TB] step=%0d rst=%0d x=%0d y=%0d act=%0d hs=%0d vs=%0d | out addr=%0d rgb=%03h tick=%0d",
               n, rst, x, y, act, hs, vs, o_addr, o_rgb, o_frame_tick);

      i_rst = rst; i_x = 10'(x); i_y = 10'(y);
      i_active = act; i_hsync = hs; i_vsync = vs;
      if (rst) begin
         e.addr = 8'd0; e.rgb = 12'h000;
         e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.quiet = 1'b1;
         for (int i = 0; i < 4; i++) ring[i] = e;
         falls = 0; prev_vs = 1'b1; last_fall = -100;
      end else begin
         if (prev_vs && !vs) begin
            falls++; falls_total++; last_fall = n;
         end
         prev_vs = vs;
         e.addr  = model_addr(x, y);
         e.rgb   = model_rgb(x, y, act, falls);
         e.act   = act; e.hs = hs; e.vs = vs;
         e.quiet = (n - last_fall) >= 3;
         ring[n % 4] = e;
      end
      prev_rst = rst;
      n++;
   endtask

   task automatic random_steps(input int count);
      int xs[13] = '{0, 95, 96, 97, 127, 128, 129, 512, 527, 543, 544, 545, 320};
      int ys[10] = '{0, 15, 16, 17, 47, 48, 463, 464, 465, 240};
      int x, y;
      for (int k = 0; k < count; k++) begin
         x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 799)) : xs[$urandom_range(0, 12)];
         y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 524)) : ys[$urandom_range(0, 9)];
         step(1'b0, x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) != 0);
      end
   endtask

   initial begin
      int hs_pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};
      int t0;
      for (int i = 0; i < 256; i++) mem[i] = 2'($urandom_range(0, 3));
      mem[0]   = 2'd2;
      mem[195] = 2'd3;

      for (int k = 0; k < 3; k++) step(1'b1, 0, 0, 1'b0, 1'b1, 1'b1);

      // directed corner pixels
      step(1'b0, 96, 16, 1'b1, 1'b1, 1'b1);
      step(1'b0, 96 + 13 * 32 + 5, 16 + 13 * 32 + 5, 1'b1, 1'b1, 1'b1);
      step(1'b0, 95, 100, 1'b1, 1'b1, 1'b1);
      step(1'b0, 544, 100, 1'b1, 1'b1, 1'b1);
      step(1'b0, 543, 100, 1'b1, 1'b1, 1'b1);
      step(1'b0, 100, 15, 1'b1, 1'b1, 1'b1);
      step(1'b0, 200, 200, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) step(1'b0, 130 + k, 60, 1'b1, hs_pat[k] != 0, 1'b1);

      // blink: food cell 0 interior pixel across 34 vsync falls
      for (int f = 0; f < 34; f++) begin
         for (int k = 0; k < 4; k++) step(1'b0, 100, 20, 1'b1, 1'b1, 1'b1);
         t0 = ticks;
         for (int k = 0; k < 6; k++) step(1'b0, 100, 20, 1'b1, 1'b1, 1'b0);
         chk("tick_per_fall", 32'(ticks - t0), 32'd1);
      end

      random_steps(1500);

      // reset mid-line with in-grid traffic around it
      for (int k = 0; k < 4; k++) step(1'b0, 300 + k, 200, 1'b1, 1'b1, 1'b1);
      step(1'b1, 305, 200, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) step(1'b0, 310 + k, 200, 1'b1, 1'b1, 1'b1);

      random_steps(500);
      for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      chk("tick_total", 32'(ticks), 32'(falls_total));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/grid_render.md
GRID_RENDER -- requirements
Module: grid_render

Interface
REQ-001 SHALL have parameters: CELL_PX default 32 (cell edge in pixels, power of 2); GRID_W default 14 (cells per row); GRID_H default 14 (cells per column); X0 default 96 (grid left pixel); Y0 default 16 (grid top pixel); ADDR_WIDTH default 8; DATA_WIDTH default 2.
REQ-002 SHALL have port i_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports i_x and i_y, inputs, 10 bits each: current pixel coordinates from the VGA timing generator.
REQ-005 SHALL have ports i_active, i_hsync and i_vsync, inputs, 1 bit each: display-enable and syncs aligned with i_x/i_y; i_vsync is active-low.
REQ-006 SHALL have port o_addr, output, ADDR_WIDTH bits: cell address driven to the grid memory read port.
REQ-007 SHALL have port i_cell, input, DATA_WIDTH bits: cell code from the memory read port, valid the cycle after o_addr is captured by the memory.
REQ-008 SHALL have port o_rgb, output, 12 bits: pixel colour {R[3:0],G[3:0],B[3:0]}.
REQ-009 SHALL have ports o_active, o_hsync and o_vsync, outputs, 1 bit each: inputs delayed to align with o_rgb.
REQ-010 SHALL have port o_frame_tick, output, 1 bit: one-cycle pulse on each falling edge of i_vsync.

Function
REQ-011 Stage 1 (registered): in_grid = X0<=i_x<X0+GRID_W*CELL_PX and Y0<=i_y<Y0+GRID_H*CELL_PX; col=(i_x-X0)/CELL_PX, row=(i_y-Y0)/CELL_PX (shifts, no divider); o_addr<=row*GRID_W+col when in_grid, else 0.
REQ-012 Stage 2: the memory registers o_addr; i_cell is sampled at the end of this stage; in_grid, edge flag and syncs are carried alongside.
REQ-013 Stage 3 (registered): o_rgb computed from the stage-2 i_cell and side-band; total latency from i_x/i_y to o_rgb SHALL be exactly 3 cycles.
REQ-014 o_active/o_hsync/o_vsync SHALL be i_active/i_hsync/i_vsync delayed by exactly 3 cycles.
REQ-015 Colour map: out of grid 12'h000; cell 0 (empty) 12'h222; cell 1 (body) 12'h0F0; cell 2 (food) 12'hF00 when blink phase=1, else 12'h222; cell 3 (head) 12'hFF0.
REQ-016 Edge flag: in_grid and (x-X0)%CELL_PX==0 or (y-Y0)%CELL_PX==0 -> o_rgb=12'h444, overriding the cell code.
REQ-017 o_rgb SHALL be 12'h000 whenever the delayed active is 0, overriding REQ-015/016.
REQ-018 Frame counter: a 5-bit counter increments on each o_frame_tick and wraps from 31 to 0; blink phase = counter bit 4 (16 frames on, 16 frames off).
REQ-019 o_frame_tick SHALL be detected from a registered copy of i_vsync (prev=1, cur=0); it is not pipeline-delayed.
REQ-020 Boundaries: x=X0+GRID_W*CELL_PX-1 maps to col GRID_W-1; x=X0+GRID_W*CELL_PX is out of grid; the maximum address GRID_W*GRID_H-1 (195) SHALL never be exceeded.
REQ-021 Coordinates below X0/Y0 SHALL NOT underflow into in_grid (compare before subtracting).

Reset
REQ-022 While i_rst=1 at an edge: all pipeline registers cleared; o_addr=0, o_rgb=0, o_active=0, o_hsync=1, o_vsync=1, o_frame_tick=0, frame counter=0, registered vsync=1.
REQ-023 A reset mid-frame SHALL take effect at the next edge; outputs are valid 3 cycles after i_rst falls, with no spurious o_frame_tick on the first cycle.

Verification
REQ-024 (x,y)=(96,16), i_active=1 -> o_addr=0 after 1 cycle; o_rgb=12'h444 (edge) after 3 cycles.
REQ-025 (x,y)=(96+13*32+5, 16+13*32+5) with memory[195]=3 -> o_addr=195; o_rgb=12'hFF0 after 3 cycles.
REQ-026 (x,y)=(95,100) and (544,100) -> o_addr=0; o_rgb=12'h000.
REQ-027 Cell code 2 over 32 vsync falls -> o_rgb=12'h222 for frames 0-15 and 12'hF00 for frames 16-31; exactly one o_frame_tick per fall.
REQ-028 i_hsync pulse pattern -> o_hsync is the same pattern shifted by exactly 3 cycles; i_active=0 in grid -> o_rgb=0.
REQ-029 Assert i_rst mid-line -> all outputs at reset values the next cycle; first valid colour appears 3 cycles after release.
